adder_display_scanner: RTL

Parametrised successor to the single-digit adder display. It adds two WIDTH-bit switch operands and converts the sum to decimal with a sequential double-dabble engine. The result is shown on up to 8 time-multiplexed seven-segment digits, with leading-zero blanking and an overflow indication. It is the top-level board driver: switches in, active-low segments and anodes out.

---
 rtl/adder_display_scanner_if.sv | 14 +
 rtl/adder_display_scanner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_display_scanner_if.sv
// Display-side bundle of the adder scanner: switch operands in, binary sum,
// active-low segments/anodes out.
interface adder_display_scanner_if #(
    parameter int WIDTH = 4
);
    logic [2*WIDTH-1:0] sw;
    logic [WIDTH:0]     led;
    logic [6:0]         seg;   // {g,f,e,d,c,b,a}, active-low
    logic               dp;
    logic [7:0]         an;

    modport master (output sw, input led, seg, dp, an);
    modport slave  (input sw, output led, seg, dp, an);
endinterface

// File: rtl/adder_display_scanner.sv
// Switch adder with sequential double-dabble BCD conversion and a
// time-multiplexed seven-segment scanner (leading-zero blanking, overflow dash).
module adder_display_scanner_core #(
    parameter int WIDTH       = 4,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    adder_display_scanner_if.slave bus
);
    localparam int SUM_W = WIDTH + 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DIGITS - 1);
    localparam logic [6:0]       SEG_DASH = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LOAD
    } state_e;

    state_e             state_q, state_d;
    logic [SUM_W-1:0]   cap_q, cap_d;
    logic [SUM_W-1:0]   bin_q, bin_d;
    logic [31:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        disp_q, disp_d;
    logic               ovf_q, ovf_d;
    logic [SUM_W-1:0]   led_q, led_d;
    logic [REF_W-1:0]   ref_q, ref_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;

    logic [SUM_W-1:0]   sum;
    logic               hi_nz;
    logic [31:0]        upper;
    logic [3:0]         nib;
    logic               blank;

    function automatic logic [31:0] dd_adjust(input logic [31:0] v);
        logic [31:0] r;
        r = v;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign sum   = SUM_W'(bus.sw[WIDTH-1:0]) + SUM_W'(bus.sw[2*WIDTH-1:WIDTH]);
    assign hi_nz = |(bcd_q >> (4 * DIGITS));

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        led_d   = led_q;
        unique case (state_q)
            S_IDLE: begin
                cap_d   = sum;
                bin_d   = sum;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                {bcd_d, bin_d} = {dd_adjust(bcd_q), bin_q} << 1;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = S_LOAD;
            end
            S_LOAD: begin
                // Display, LED and overflow commit together so no partial result is ever shown
                disp_d  = bcd_q;
                led_d   = cap_q;
                ovf_d   = hi_nz;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ref_d = ref_q + REF_W'(1);
        idx_d = idx_q;
        if (ref_q == REF_LAST) begin
            ref_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 3'd1;
        end
        nib   = disp_q[{idx_q, 2'b00} +: 4];
        upper = disp_q >> {idx_q, 2'b00};
        // Without overflow every nibble above DIGITS-1 is zero, so a zero upper slice means leading zero
        blank = BLANK_LZ && (idx_q != 3'd0) && (upper == '0);
        an_d  = '1;
        seg_d = '1;
        if (ovf_q) begin
            an_d[idx_q] = 1'b0;
            seg_d       = SEG_DASH;
        end else if (!blank) begin
            an_d[idx_q] = 1'b0;
            seg_d       = seg7(nib);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cap_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            led_q   <= '0;
            ref_q   <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= '1;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            led_q   <= led_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.led = led_q;
    assign bus.seg = seg_q;
    assign bus.an  = an_q;
    assign bus.dp  = 1'b1;
endmodule

module adder_display_scanner #(
    parameter int WIDTH       = 4,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic               CLK100MHZ,
    input  logic               CPU_RESETN,
    input  logic [2*WIDTH-1:0] SW,
    output logic [WIDTH:0]     LED,
    output logic               CA,
    output logic               CB,
    output logic               CC,
    output logic               CD,
    output logic               CE,
    output logic               CF,
    output logic               CG,
    output logic               DP,
    output logic [7:0]         AN
);
    adder_display_scanner_if #(.WIDTH(WIDTH)) bus ();

    assign bus.sw = SW;

    adder_display_scanner_core #(
        .WIDTH      (WIDTH),
        .DIGITS     (DIGITS),
        .REFRESH_DIV(REFRESH_DIV),
        .BLANK_LZ   (BLANK_LZ)
    ) u_core (
        .clk_i (CLK100MHZ),
        .rst_ni(CPU_RESETN),
        .bus   (bus)
    );

    assign LED                          = bus.led;
    assign {CG, CF, CE, CD, CC, CB, CA} = bus.seg;
    assign DP                           = bus.dp;
    assign AN                           = bus.an;
endmodule
